// File: rtl/hb15_dec_if.sv
// rtl/hb15_dec_if.sv - strobed sample stream between receive DSP stages
interface hb15_dec_if #(parameter int WIDTH = 18);
   logic                    stb;
   logic signed [WIDTH-1:0] data;

   modport master (output stb, output data);
   modport slave  (input  stb, input  data);
endinterface

// File: rtl/hb15_dec.sv
// rtl/hb15_dec.sv - 15-tap halfband decimate-by-2 with one time-shared multiplier
// Optional sticky overrun flag built only when HB15_DEC_OVERRUN_EN is defined.
module hb15_dec #(
   parameter int WIDTH = 18
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_bypass,
   input  logic       i_run,
   hb15_dec_if.slave  i_smp,
   hb15_dec_if.master o_smp,
   output logic       o_overrun
);
   localparam int PW = WIDTH + 1;
   localparam int MW = PW + 18;
   localparam int AW = WIDTH + 21;

   localparam logic signed [17:0]   C0  = 18'sd80568;
   localparam logic signed [17:0]   C1  = -18'sd19394;
   localparam logic signed [17:0]   C2  = 18'sd5594;
   localparam logic signed [17:0]   C3  = -18'sd1232;
   localparam logic signed [AW-1:0] RND = AW'(131072);

   typedef enum logic [1:0] {S_IDLE, S_MAC1, S_MAC2, S_MAC3} state_t;

   logic signed [WIDTH-1:0] r_x [0:14];
   logic signed [WIDTH-1:0] w_xn [0:14];
   logic                    r_phase;
   state_t                  r_state;
   logic signed [PW-1:0]    r_p1, r_p2, r_p3;
   logic signed [WIDTH-1:0] r_center;
   logic signed [MW-1:0]    r_prod;
   logic signed [AW-1:0]    r_acc;
   logic [6:0]              r_tag;
   logic signed [WIDTH-1:0] r_y;
   logic                    r_stb_out;
   logic signed [WIDTH-1:0] r_data_out;

   logic                    w_go, w_accept;
   logic signed [PW-1:0]    w_p0, w_mul_a;
   logic signed [17:0]      w_mul_b;
   logic signed [AW-1:0]    w_sum, w_q;
   logic signed [WIDTH-1:0] w_y;

   // Post-shift view of the delay line: the pair sums use the sample arriving this cycle.
   always_comb begin
      w_xn[0] = i_smp.data;
      for (int k = 1; k < 15; k++) w_xn[k] = r_x[k-1];
   end

   assign w_go     = i_smp.stb & i_run & r_phase;
   assign w_accept = w_go & (r_state == S_IDLE);
   assign w_p0     = PW'(w_xn[6]) + PW'(w_xn[8]);

   // The c0 product issues on the go edge itself, so the sequencer is idle again 4 cycles later.
   always_comb begin
      w_mul_a = w_p0;
      w_mul_b = C0;
      case (r_state)
         S_MAC1:  begin w_mul_a = r_p1; w_mul_b = C1; end
         S_MAC2:  begin w_mul_a = r_p2; w_mul_b = C2; end
         S_MAC3:  begin w_mul_a = r_p3; w_mul_b = C3; end
         default: ;
      endcase
   end

   always_comb begin
      w_sum = r_acc + RND;
      w_q   = w_sum >>> 18;
      if (w_q[AW-1:WIDTH-1] == {(AW-WIDTH+1){w_q[AW-1]}})
         w_y = w_q[WIDTH-1:0];
      else if (w_q[AW-1])
         w_y = {1'b1, {(WIDTH-1){1'b0}}};
      else
         w_y = {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 15; k++) r_x[k] <= '0;
         r_phase    <= 1'b0;
         r_state    <= S_IDLE;
         r_p1       <= '0;
         r_p2       <= '0;
         r_p3       <= '0;
         r_center   <= '0;
         r_prod     <= '0;
         r_acc      <= '0;
         r_tag      <= '0;
         r_y        <= '0;
         r_stb_out  <= 1'b0;
         r_data_out <= '0;
      end else begin
         if (i_smp.stb) begin
            for (int k = 0; k < 15; k++) r_x[k] <= w_xn[k];
         end
         r_prod <= MW'(w_mul_a) * MW'(w_mul_b);

         if (!i_run) begin
            r_phase <= 1'b0;
            r_state <= S_IDLE;
            r_tag   <= '0;
         end else begin
            if (i_smp.stb) r_phase <= ~r_phase;
            r_tag <= {r_tag[5:0], w_accept};
            case (r_state)
               S_IDLE: if (w_accept) begin
                  r_p1     <= PW'(w_xn[4]) + PW'(w_xn[10]);
                  r_p2     <= PW'(w_xn[2]) + PW'(w_xn[12]);
                  r_p3     <= PW'(w_xn[0]) + PW'(w_xn[14]);
                  r_center <= w_xn[7];
                  r_state  <= S_MAC1;
               end
               S_MAC1:  r_state <= S_MAC2;
               S_MAC2:  r_state <= S_MAC3;
               default: r_state <= S_IDLE;
            endcase
         end

         // r_tag[k] marks the cycle k+1 after an accepted go.
         if (r_tag[0])
            r_acc <= (AW'(r_center) <<< 17) + AW'(r_prod);
         else if (|r_tag[3:1])
            r_acc <= r_acc + AW'(r_prod);
         if (r_tag[4]) r_y <= w_y;

         if (i_bypass) begin
            r_stb_out  <= i_smp.stb;
            r_data_out <= i_smp.data;
         end else begin
            r_stb_out <= r_tag[6] & i_run;
            if (r_tag[6] & i_run) r_data_out <= r_y;
         end
      end
   end

   assign o_smp.stb  = r_stb_out;
   assign o_smp.data = r_data_out;

`ifdef HB15_DEC_OVERRUN_EN
   logic r_overrun;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_run)
         r_overrun <= 1'b0;
      else if (w_go && r_state != S_IDLE)
         r_overrun <= 1'b1;
   end
   assign o_overrun = r_overrun;
`else
   assign o_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_hb15_dec.sv
// tb/tb_hb15_dec.sv - self-checking bench for hb15_dec against a convolution model
module tb_hb15_dec;
   localparam int W  = 18;
   localparam int NC = 4096;
`ifdef HB15_DEC_OVERRUN_EN
   localparam int OVR_EN = 1;
`else
   localparam int OVR_EN = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, run, bypass, ovr;
   hb15_dec_if #(.WIDTH(W)) u_in ();
   hb15_dec_if #(.WIDTH(W)) u_out ();

   hb15_dec #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_bypass  (bypass),
      .i_run     (run),
      .i_smp     (u_in),
      .o_smp     (u_out),
      .o_overrun (ovr)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   int h [0:14] = '{-1232, 0, 5594, 0, -19394, 0, 80568, 131072, 80568, 0, -19394, 0, 5594, 0, -1232};
   int imp1 [0:7] = '{-5, 21, -74, 307, 307, -74, 21, -5};

   bit filt_stb [0:NC-1];
   int filt_val [0:NC-1];
   bit exp_stb  [0:NC-1];
   int exp_dat  [0:NC-1];
   bit exp_ovr  [0:NC-1];
   int xs [0:14];
   bit m_phase = 1'b0;
   int busy_until = 0;
   bit m_ovr = 1'b0;
   int m_dout = 0;
   int got_val[$];
   int got_cyc[$];
   int go_cyc[$];

   // y[n] = sum h[k] x[n-k], rounded half up at 2^-18, saturated to the output range.
   function automatic int filt_out();
      longint acc = 0;
      for (int k = 0; k < 15; k++) acc += longint'(h[k]) * longint'(xs[k]);
      acc = (acc + 131072) >>> 18;
      if (acc > 131071)  acc = 131071;
      if (acc < -131072) acc = -131072;
      return int'(acc);
   endfunction

   task automatic model(input bit r, input bit rn, input bit bp, input bit s, input int d);
      int nx;
      bit go;
      nx = cyc + 1;
      if (!r) begin
         for (int k = 0; k < 15; k++) xs[k] = 0;
         m_phase = 1'b0;
         busy_until = 0;
         m_ovr = 1'b0;
         for (int j = nx; j <= cyc + 8; j++) filt_stb[j] = 1'b0;
         exp_stb[nx] = 1'b0;
         m_dout = 0;
      end else begin
         go = s && rn && m_phase;
         if (s) begin
            for (int k = 14; k > 0; k--) xs[k] = xs[k-1];
            xs[0] = d;
         end
         if (!rn) m_phase = 1'b0;
         else if (s) m_phase = !m_phase;
         if (go) begin
            if (cyc >= busy_until) begin
               busy_until = cyc + 4;
               filt_stb[cyc+8] = 1'b1;
               filt_val[cyc+8] = filt_out();
               go_cyc.push_back(cyc);
            end else if (OVR_EN != 0) begin
               m_ovr = 1'b1;
            end
         end
         if (!rn) begin
            busy_until = 0;
            m_ovr = 1'b0;
            for (int j = nx; j <= cyc + 8; j++) filt_stb[j] = 1'b0;
         end
         if (bp) begin
            exp_stb[nx] = s;
            m_dout = d;
         end else begin
            exp_stb[nx] = filt_stb[nx];
            if (filt_stb[nx]) m_dout = filt_val[nx];
         end
      end
      exp_dat[nx] = m_dout;
      exp_ovr[nx] = m_ovr;
   endtask

   task automatic tick(input bit r, input bit rn, input bit bp, input bit s, input int d);
      rst_n = r;
      run = rn;
      bypass = bp;
      u_in.stb = s;
      u_in.data = d[W-1:0];
      model(r, rn, bp, s, d);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input bit rn);
      repeat (n) tick(1'b1, rn, 1'b0, 1'b0, 0);
   endtask

   task automatic feed(input int d, input int gap);
      tick(1'b1, 1'b1, 1'b0, 1'b1, d);
      repeat (gap - 1) tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic clear_logs();
      got_val.delete();
      got_cyc.delete();
      go_cyc.delete();
   endtask

   always @(negedge clk) begin
      logic [W-1:0] ev;
      if (cmp_en) begin
         ev = exp_dat[cyc][W-1:0];
         checks++;
         if (u_out.stb !== exp_stb[cyc]) begin
            failures++;
            $display("FAIL stb_out cyc=%0d got=%b exp=%b", cyc, u_out.stb, exp_stb[cyc]);
         end
         checks++;
         if (u_out.data !== ev) begin
            failures++;
            $display("FAIL data_out cyc=%0d got=%0d exp=%0d", cyc, u_out.data, $signed(ev));
         end
         checks++;
         if (ovr !== exp_ovr[cyc]) begin
            failures++;
            $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, ovr, exp_ovr[cyc]);
         end
         if (u_out.stb === 1'b1) begin
            got_val.push_back(int'(u_out.data));
            got_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      int mx;
      int d;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
      cmp_en = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("reset_stb", int'(u_out.stb), 0);
      chk("reset_data", int'(u_out.data), 0);
      chk("reset_ovr", int'(ovr), 0);

      // Impulse on the second sample of a pair.
      idle(1, 1'b0);
      clear_logs();
      feed(0, 2);
      feed(1000, 2);
      repeat (18) feed(0, 2);
      idle(10, 1'b1);
      chk("imp1_count", got_val.size(), 10);
      for (int i = 0; i < 8; i++) chk($sformatf("imp1_y%0d", i), got_val[i], imp1[i]);
      chk("imp1_tail", got_val[8], 0);

      // Impulse on the first sample of a pair, with latency pinned at 8.
      idle(1, 1'b0);
      clear_logs();
      feed(1000, 2);
      repeat (19) feed(0, 2);
      idle(10, 1'b1);
      for (int i = 0; i < 3; i++) chk($sformatf("imp0_y%0d", i), got_val[i], 0);
      chk("imp0_centre", got_val[3], 500);
      chk("imp0_tail", got_val[4], 0);
      for (int i = 0; i < 4; i++) chk($sformatf("imp0_lat%0d", i), got_cyc[i] - go_cyc[i], 8);

      // DC, Nyquist and clipped step.
      clear_logs();
      repeat (24) feed(10000, 2);
      idle(10, 1'b1);
      chk("dc_final", got_val[got_val.size()-1], 10000);
      clear_logs();
      for (int i = 0; i < 24; i++) feed((i % 2 == 0) ? 100000 : -100000, 2);
      idle(10, 1'b1);
      chk("nyq_final", got_val[got_val.size()-1], 0);
      repeat (16) feed(0, 2);
      clear_logs();
      repeat (24) feed(131071, 2);
      idle(10, 1'b1);
      mx = -200000;
      foreach (got_val[i]) if (got_val[i] > mx) mx = got_val[i];
      chk("step_max", mx, 131071);
      chk("step_final", got_val[got_val.size()-1], 131071);

      // Back-to-back strobes overrun the sequencer.
      idle(1, 1'b0);
      clear_logs();
      repeat (24) feed(2000, 1);
      idle(10, 1'b1);
      chk("ovr_count", got_val.size(), 6);
      chk("ovr_flag", int'(ovr), OVR_EN);
      idle(1, 1'b0);
      chk("ovr_cleared", int'(ovr), 0);
      repeat (16) feed(3000, 2);
      idle(10, 1'b1);
      chk("spacing2_ovr", int'(ovr), 0);

      // Reset 4 cycles after a go kills its output.
      idle(1, 1'b0);
      clear_logs();
      feed(7000, 1);
      feed(7000, 1);
      idle(3, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("rst_abort_stb", int'(u_out.stb), 0);
      chk("rst_abort_data", int'(u_out.data), 0);
      chk("rst_abort_ovr", int'(ovr), 0);
      idle(10, 1'b1);
      chk("rst_abort_count", got_val.size(), 0);

      // run pulsed low mid-compute, then a fresh pair starting at phase 0.
      clear_logs();
      feed(0, 1);
      feed(0, 1);
      idle(2, 1'b1);
      idle(1, 1'b0);
      idle(10, 1'b1);
      chk("run_abort_count", got_val.size(), 0);
      feed(0, 2);
      feed(1000, 2);
      repeat (6) feed(0, 2);
      idle(10, 1'b1);
      chk("run_restart_y0", got_val[0], -5);
      chk("run_restart_y1", got_val[1], 21);

      // Bypass with random strobes and data.
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom_range(0, 262143)) - 131072;
         tick(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), d);
      end
      idle(12, 1'b1);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
